// File: rtl/mod_addsub_pipe_if.sv
// Handshake bundle for the pipelined modular add/subtract unit: operand
// stream in, result stream out, modulus and the sticky range-error flag.
interface mod_addsub_pipe_if #(
  parameter int WIDTH = 28,
  parameter int TAG_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [TAG_W-1:0] in_tag;
  logic [WIDTH-1:0] q;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             clr_err;
  logic             range_err;

  modport slave (
    input  in_valid, in_sub, in_x, in_y, in_tag, q, out_ready, clr_err,
    output in_ready, out_valid, out_data, out_tag, range_err
  );

  modport master (
    output in_valid, in_sub, in_x, in_y, in_tag, q, out_ready, clr_err,
    input  in_ready, out_valid, out_data, out_tag, range_err
  );
endinterface

// File: rtl/mod_addsub_pipe.sv
// Two-stage modular add/subtract for the NTT datapath: stage 1 forms the raw
// x+y or x-y, stage 2 folds it back into [0, q). Tags ride along unchanged.
module mod_addsub_pipe #(
  parameter int WIDTH = 28,
  parameter int TAG_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  mod_addsub_pipe_if.slave   bus
);

  function automatic logic f_out_of_range(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [WIDTH-1:0] m
  );
    return (x >= m) || (y >= m);
  endfunction

  logic             r_s1_valid;
  logic             r_s1_sub;
  logic [WIDTH:0]   r_s1_raw;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_data;
  logic [TAG_W-1:0] r_s2_tag;

  logic             r_range_err;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_in_fire;
  logic [WIDTH:0]   w_x_ext;
  logic [WIDTH:0]   w_y_ext;
  logic [WIDTH:0]   w_raw;
  logic             w_ge_q;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_result;

  // Pipeline advance: a stage may load when empty or when its successor drains.
  always_comb begin
    w_s2_load = (!r_s2_valid) || bus.out_ready;
    w_s1_load = (!r_s1_valid) || w_s2_load;
    w_in_fire = bus.in_valid && w_s1_load;
  end

  // Stage-1 raw value; subtract wraps to WIDTH+1 bits so bit WIDTH flags x < y.
  always_comb begin
    w_x_ext = {1'b0, bus.in_x};
    w_y_ext = {1'b0, bus.in_y};
    if (bus.in_sub) begin
      w_raw = w_x_ext - w_y_ext;
    end else begin
      w_raw = w_x_ext + w_y_ext;
    end
  end

  // Stage-2 correction: only the low WIDTH bits of r -/+ q are ever kept, so
  // the correction term is formed at WIDTH bits and the select uses r itself.
  always_comb begin
    w_ge_q = (r_s1_raw >= {1'b0, bus.q});
    if (r_s1_sub) begin
      w_c = r_s1_raw[WIDTH-1:0] + bus.q;
      if (r_s1_raw[WIDTH]) begin
        w_result = w_c;
      end else begin
        w_result = r_s1_raw[WIDTH-1:0];
      end
    end else begin
      w_c = r_s1_raw[WIDTH-1:0] - bus.q;
      if (w_ge_q) begin
        w_result = w_c;
      end else begin
        w_result = r_s1_raw[WIDTH-1:0];
      end
    end
  end

  // Stage-1 register: holds while stalled, captures a beat on input transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sub   <= 1'b0;
      r_s1_raw   <= {(WIDTH+1){1'b0}};
      r_s1_tag   <= {TAG_W{1'b0}};
    end else if (w_s1_load) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_sub <= bus.in_sub;
        r_s1_raw <= w_raw;
        r_s1_tag <= bus.in_tag;
      end
    end
  end

  // Stage-2 register drives the result port directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= {WIDTH{1'b0}};
      r_s2_tag   <= {TAG_W{1'b0}};
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_result;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

  // Sticky operand range flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_range_err <= 1'b0;
    end else if (w_in_fire && f_out_of_range(bus.in_x, bus.in_y, bus.q)) begin
      r_range_err <= 1'b1;
    end else if (bus.clr_err) begin
      r_range_err <= 1'b0;
    end
  end

  assign bus.in_ready  = w_s1_load;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;
  assign bus.out_tag   = r_s2_tag;
  assign bus.range_err = r_range_err;

endmodule
